// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM state type and APB bus widths for the APB master.
package apb_master_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating count of ACCESS wait states; flags the last allowed one.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic nreset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk) begin
        if (!nreset || clear)
            cnt <= '0;
        else if (count_en && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    // cnt holds the waits already seen, so LAST means this stalled cycle is the final one allowed
    assign expired = (TIMEOUT_CYCLES > 0) && count_en && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding command-to-APB bridge with wait-state timeout.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  nreset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [APB_DATA_W-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  resp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_ADDR_W-1:0] PADDR,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_t state;
    logic       accept;
    logic       expired;

    // gated by nreset so the master never offers a slot while held in reset
    assign cmd_ready = nreset && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .pclk     (pclk),
        .nreset   (nreset),
        .clear    (accept),
        .count_en ((state == ACCESS) && !PREADY),
        .expired  (expired)
    );

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state        <= IDLE;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    state  <= SETUP;
                    PSEL   <= 1'b1;
                    PWRITE <= cmd_write;
                    PADDR  <= cmd_addr;
                    PWDATA <= cmd_wdata;
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: if (PREADY || expired) begin
                    state        <= RESP;
                    PSEL         <= 1'b0;
                    PENABLE      <= 1'b0;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                    resp_err     <= PREADY ? PSLVERR : 1'b1;
                    resp_timeout <= !PREADY;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard bench driving commands and an APB slave model into apb_master.
module tb_apb_master;

    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    logic        pclk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk         (pclk),
        .nreset       (nreset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transfer: push expectation, drive command, play slave with `waits` stall cycles, drain response
    task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d, input int waits,
                        input logic serr, input logic [31:0] rd, input int hold);
        exp_t e;
        exp_t got;
        logic tmo;
        logic stable;
        logic quiet;
        int   n;
        int   lim;
        tmo     = (TO > 0) && (waits >= TO);
        e.rdata = (w || tmo) ? 32'h0 : rd;
        e.err   = tmo || serr;
        e.tmo   = tmo;
        lim     = tmo ? TO : waits + 1;
        sb.push_back(e);
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;
        PRDATA    = 32'hBAD0BAD0;
        check("setup_ctl", {21'b0, PSEL, PENABLE, PWRITE, PADDR}, {21'b0, 1'b1, 1'b0, w, a});
        check("setup_wdata", PWDATA, d);
        n = 0;
        stable = 1'b1;
        @(negedge pclk);
        while (PSEL && PENABLE && n < 100) begin
            n++;
            stable  = stable && (PADDR == a) && (PWDATA == d) && (PWRITE == w);
            PREADY  = (n == waits + 1);
            PRDATA  = PREADY ? rd : $urandom;
            PSLVERR = PREADY ? serr : 1'b1;
            @(negedge pclk);
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check("acc_len", n, lim);
        check("addr_stable", {31'b0, stable}, 32'd1);
        check("resp_valid", {31'b0, resp_valid}, 32'd1);
        check("resp_psel", {30'b0, PSEL, PENABLE}, 32'd0);
        got = {resp_rdata, resp_err, resp_timeout};
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("resp_rdata", got.rdata, e.rdata);
            check("resp_err", {31'b0, got.err}, {31'b0, e.err});
            check("resp_timeout", {31'b0, got.tmo}, {31'b0, e.tmo});
        end
        quiet = 1'b1;
        repeat (hold) begin
            @(negedge pclk);
            quiet = quiet && resp_valid && !cmd_ready && !PSEL && ({resp_rdata, resp_err, resp_timeout} == got);
        end
        if (hold > 0) check("resp_hold", {31'b0, quiet}, 32'd1);
        resp_ready = 1'b1;
        @(negedge pclk);
        resp_ready = 1'b0;
        check("resp_drop", {31'b0, resp_valid}, 32'd0);
        check("idle_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        check("rst_ready", {31'b0, cmd_ready}, 32'd0);
        check("rst_resp", {28'b0, resp_valid, resp_err, resp_timeout, 1'b0}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_apb", {21'b0, PSEL, PENABLE, PWRITE, PADDR}, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        nreset = 1'b1;
        #1;
        check("first_idle_ready", {31'b0, cmd_ready}, 32'd1);

        xfer(1'b1, 8'h08, 32'h00000001, 0, 1'b0, 32'h12345678, 0);
        xfer(1'b0, 8'h04, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0);
        xfer(1'b0, 8'h10, 32'h0, 16, 1'b0, 32'h00000055, 1);
        xfer(1'b1, 8'h20, 32'h000000A5, 15, 1'b0, 32'h00000066, 0);
        xfer(1'b0, 8'h30, 32'h0, 0, 1'b1, 32'hCAFEF00D, 5);
        xfer(1'b1, 8'h40, 32'h11223344, 40, 1'b0, 32'h77, 2);
        xfer(1'b0, 8'hFC, 32'h0, 15, 1'b0, 32'h89ABCDEF, 0);

        // Abandon a transfer mid-ACCESS and confirm no stray response appears
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h50;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("pre_rst_access", {30'b0, PSEL, PENABLE}, 32'd3);
        nreset = 1'b0;
        @(negedge pclk);
        check("mid_rst_apb", {29'b0, PSEL, PENABLE, resp_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
        nreset = 1'b1;
        @(negedge pclk);
        check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (3) @(negedge pclk);
        check("post_rst_quiet", {30'b0, resp_valid, PSEL}, 32'd0);
        xfer(1'b0, 8'h44, 32'h0, 1, 1'b0, 32'h0BADCAFE, 0);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
